// File: rtl/sram_bank_arbiter_if.sv
// Handshake and SRAM-wrapper bundle for sram_bank_arbiter.
// The slave modport is the arbiter's view; master is the requester/wrapper side.
interface sram_bank_arbiter_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4
);
  localparam int ROW_WIDTH = FETCH_WIDTH * DATA_WIDTH;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ROW_WIDTH-1:0]  wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic                  rd_rsp_valid;
  logic                  rd_rsp_ready;
  logic [ROW_WIDTH-1:0]  rd_rsp_data;

  logic [ADDR_WIDTH-1:0] mem_addr_in_bank;
  logic                  mem_cen_in_bank;
  logic                  mem_wen_in_bank;
  logic [ROW_WIDTH-1:0]  mem_data_in_bank;
  logic [ROW_WIDTH-1:0]  mem_data_out_bank;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_addr,
    input  rd_rsp_ready,
    input  mem_data_out_bank,
    output wr_ready, rd_ready,
    output rd_rsp_valid, rd_rsp_data,
    output mem_addr_in_bank, mem_cen_in_bank, mem_wen_in_bank, mem_data_in_bank
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_valid, rd_addr,
    output rd_rsp_ready,
    output mem_data_out_bank,
    input  wr_ready, rd_ready,
    input  rd_rsp_valid, rd_rsp_data,
    input  mem_addr_in_bank, mem_cen_in_bank, mem_wen_in_bank, mem_data_in_bank
  );
endinterface

// File: rtl/sram_bank_arbiter.sv
// Round-robin write/read arbiter in front of a single-port SRAM bank, with a
// 2-entry read response buffer and credit-based read throttling.
module sram_bank_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  sram_bank_arbiter_if.slave    bus
);
  localparam int ROW_WIDTH = FETCH_WIDTH * DATA_WIDTH;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

  grant_e               last_grant;
  logic                 read_inflight;
  logic [1:0]           fifo_count;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [ROW_WIDTH-1:0] fifo_mem [2];

  logic       push;
  logic       pop;
  logic [1:0] outstanding;
  logic [1:0] credit_used;
  logic       wr_elig;
  logic       rd_elig;
  logic       wr_grant;
  logic       rd_grant;

  // Credits count reads already issued but not yet consumed; a pop this cycle
  // frees its slot early so streaming sustains one read per cycle.
  // NOTE: every always_comb output gets a value on every path to avoid latches.
  always_comb begin
    push        = read_inflight;
    pop         = (fifo_count != 2'd0) && bus.rd_rsp_ready;
    outstanding = fifo_count + {1'b0, read_inflight};
    credit_used = outstanding - {1'b0, pop};
    wr_elig     = bus.wr_valid && clk_en;
    rd_elig     = bus.rd_valid && clk_en && (credit_used < 2'd2);
    wr_grant    = wr_elig && (!rd_elig || (last_grant == GRANT_READ));
    rd_grant    = rd_elig && !wr_grant;
  end

  assign bus.wr_ready         = wr_grant;
  assign bus.rd_ready         = rd_grant;
  assign bus.mem_cen_in_bank  = wr_grant || rd_grant;
  assign bus.mem_wen_in_bank  = wr_grant;
  assign bus.mem_addr_in_bank = wr_grant ? bus.wr_addr :
                                rd_grant ? bus.rd_addr : '0;
  assign bus.mem_data_in_bank = wr_grant ? bus.wr_data : '0;

  assign bus.rd_rsp_valid = (fifo_count != 2'd0);
  assign bus.rd_rsp_data  = fifo_mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant    <= GRANT_READ;
      read_inflight <= 1'b0;
      fifo_count    <= 2'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
    end else begin
      if (wr_grant) last_grant <= GRANT_WRITE;
      else if (rd_grant) last_grant <= GRANT_READ;
      read_inflight <= rd_grant;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: buffer storage is not reset; fifo_count gates visibility, so stale
  // contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_data_out_bank;
  end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed self-checking bench for sram_bank_arbiter with a behavioural
// 256 x 64-bit single-port SRAM model behind the arbiter.
module tb_sram_bank_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  int   total = 0;
  int   bad   = 0;

  sram_bank_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .FETCH_WIDTH(4)) bus ();

  sram_bank_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .FETCH_WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: write on the edge ending the grant, Q registered one cycle later.
  logic [63:0] sram [256];
  logic [63:0] sram_q = '0;
  always @(posedge clk) begin
    if (bus.mem_cen_in_bank) begin
      if (bus.mem_wen_in_bank) sram[bus.mem_addr_in_bank] <= bus.mem_data_in_bank;
      else sram_q <= sram[bus.mem_addr_in_bank];
    end
  end
  assign bus.mem_data_out_bank = sram_q;

  function automatic logic [63:0] pat(input logic [7:0] a);
    return {4{8'hA5, a}};
  endfunction

  // Expected row contents: preload pattern, except the row written in test 1.
  function automatic logic [63:0] golden(input logic [7:0] a);
    return (a == 8'h05) ? 64'h4444_3333_2222_1111 : pat(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_valid     = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.rd_valid     = 1'b0;
    bus.rd_addr      = '0;
    bus.rd_rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    clk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Never two grants at once; never a push into a full response buffer.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("ready_onehot", {63'd0, bus.wr_ready && bus.rd_ready}, 64'd0);
      check("no_overflow",
            {63'd0, dut.read_inflight && (dut.fifo_count == 2'd2) && !bus.rd_rsp_ready}, 64'd0);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = pat(i[7:0]);
    rst_n = 1'b0;
    clk_en = 1'b1;
    idle_inputs();
    #3;
    check("rst_rsp_valid", bus.rd_rsp_valid, 0);
    check("rst_cen", bus.mem_cen_in_bank, 0);
    check("rst_addr", bus.mem_addr_in_bank, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single write then read of row 0x05.
    tick();
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h05; bus.wr_data = 64'h4444_3333_2222_1111;
    #3;
    check("w1_wr_ready", bus.wr_ready, 1);
    check("w1_cen", bus.mem_cen_in_bank, 1);
    check("w1_wen", bus.mem_wen_in_bank, 1);
    check("w1_addr", bus.mem_addr_in_bank, 8'h05);
    check("w1_data", bus.mem_data_in_bank, 64'h4444_3333_2222_1111);
    tick();
    bus.wr_valid = 1'b0; bus.wr_data = '0;
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h05; bus.rd_rsp_ready = 1'b1;
    #3;
    check("r1_rd_ready", bus.rd_ready, 1);
    check("r1_cen", bus.mem_cen_in_bank, 1);
    check("r1_wen", bus.mem_wen_in_bank, 0);
    check("r1_addr", bus.mem_addr_in_bank, 8'h05);
    tick();
    bus.rd_valid = 1'b0;
    #3;
    check("r1_t1_cen", bus.mem_cen_in_bank, 0);
    check("r1_t1_rsp_valid", bus.rd_rsp_valid, 0);
    tick();
    #3;
    check("r1_t2_cen", bus.mem_cen_in_bank, 0);
    check("r1_t2_rsp_valid", bus.rd_rsp_valid, 1);
    check("r1_t2_rsp_data", bus.rd_rsp_data, 64'h4444_3333_2222_1111);
    tick();
    #3;
    check("r1_t3_rsp_valid", bus.rd_rsp_valid, 0);

    // Contention from reset: W,R,W,R,W,R.
    do_reset();
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h10; bus.wr_data = pat(8'h10);
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h20; bus.rd_rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #3;
      check($sformatf("cont%0d_wr", i), bus.wr_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("cont%0d_rd", i), bus.rd_ready, (i % 2 == 0) ? 0 : 1);
      tick();
    end
    idle_inputs();
    bus.rd_rsp_ready = 1'b1;
    repeat (3) tick();

    // Backpressure: only two reads accepted until the first pop.
    do_reset();
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h01;
    #3 check("bp0_rd_ready", bus.rd_ready, 1);
    tick();
    bus.rd_addr = 8'h02;
    #3 check("bp1_rd_ready", bus.rd_ready, 1);
    tick();
    bus.rd_addr = 8'h03;
    #3 check("bp2_rd_ready", bus.rd_ready, 0);
    tick();
    #3;
    check("bp3_rd_ready", bus.rd_ready, 0);
    check("bp3_rsp_valid", bus.rd_rsp_valid, 1);
    check("bp3_rsp_data", bus.rd_rsp_data, golden(8'h01));
    tick();
    #3;
    check("bp4_rd_ready", bus.rd_ready, 0);
    check("bp4_rsp_hold", bus.rd_rsp_data, golden(8'h01));
    tick();
    bus.rd_rsp_ready = 1'b1;
    #3;
    check("bp5_rd_ready_on_pop", bus.rd_ready, 1);
    check("bp5_addr", bus.mem_addr_in_bank, 8'h03);
    check("bp5_rsp_data", bus.rd_rsp_data, golden(8'h01));
    tick();
    bus.rd_valid = 1'b0;
    #3;
    check("bp6_rsp_valid", bus.rd_rsp_valid, 1);
    check("bp6_rsp_data", bus.rd_rsp_data, golden(8'h02));
    tick();
    #3;
    check("bp7_rsp_valid", bus.rd_rsp_valid, 1);
    check("bp7_rsp_data", bus.rd_rsp_data, golden(8'h03));
    tick();
    #3 check("bp8_rsp_valid", bus.rd_rsp_valid, 0);
    tick();

    // Streaming: eight back-to-back reads on rows 0..7.
    bus.rd_rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.rd_valid = (i < 8);
      bus.rd_addr  = i[7:0];
      #3;
      if (i < 8) check($sformatf("st%0d_rd_ready", i), bus.rd_ready, 1);
      if (i >= 2) begin
        check($sformatf("st%0d_rsp_valid", i), bus.rd_rsp_valid, 1);
        check($sformatf("st%0d_rsp_data", i), bus.rd_rsp_data, golden(8'(i - 2)));
      end
      tick();
    end
    bus.rd_valid = 1'b0;
    #3 check("st_drained", bus.rd_rsp_valid, 0);
    tick();

    // clk_en low blocks grants but not an in-flight capture.
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h09;
    #3 check("ce_pre_rd_ready", bus.rd_ready, 1);
    tick();
    clk_en = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h30; bus.wr_data = 64'hDEAD_BEEF_0000_0001;
    for (int i = 0; i < 3; i++) begin
      #3;
      check($sformatf("ce%0d_wr_ready", i), bus.wr_ready, 0);
      check($sformatf("ce%0d_rd_ready", i), bus.rd_ready, 0);
      check($sformatf("ce%0d_cen", i), bus.mem_cen_in_bank, 0);
      if (i == 1) begin
        check("ce_rsp_valid", bus.rd_rsp_valid, 1);
        check("ce_rsp_data", bus.rd_rsp_data, golden(8'h09));
      end
      tick();
    end
    clk_en = 1'b1;
    idle_inputs();
    tick();

    // Reset mid-stream discards buffered and in-flight reads.
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h04;
    #3 check("rm0_rd_ready", bus.rd_ready, 1);
    tick();
    bus.rd_addr = 8'h06;
    #3 check("rm1_rd_ready", bus.rd_ready, 1);
    tick();
    bus.rd_valid = 1'b0;
    #3 check("rm2_rsp_valid", bus.rd_rsp_valid, 1);
    rst_n = 1'b0;
    #1 check("rm_async_drop", bus.rd_rsp_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3 check($sformatf("rm_post%0d_rsp_valid", i), bus.rd_rsp_valid, 0);
      tick();
    end
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h40; bus.wr_data = pat(8'h40);
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h41;
    #3;
    check("rm_cont_wr", bus.wr_ready, 1);
    check("rm_cont_rd", bus.rd_ready, 0);
    tick();
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_bank_arbiter.md
# sram_bank_arbiter

Sequencing and arbitration controller placed in front of the single-port TSMC SRAM bank wrapper (256 × 64-bit, presented as 4 × 16-bit words). It shares the bank between one write requester and one read requester through valid/ready handshakes, issues at most one access per cycle, and arbitrates round-robin on contention. It returns read data through a 2-entry response buffer with credit-based read throttling, so the read requester can stall the response port without losing data.

## Interface
Parameters:
- ADDR_WIDTH, 8, SRAM word address width (256 entries)
- DATA_WIDTH, 16, width of one sub-word
- FETCH_WIDTH, 4, sub-words per SRAM word (64-bit row)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  issue enable; low blocks new grants only
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  FETCH_WIDTH×DATA_WIDTH  write row
- rd_valid  in  1  read request
- rd_ready  out  1  read accepted this cycle
- rd_addr  in  ADDR_WIDTH  read address
- rd_rsp_valid  out  1  response buffer head valid
- rd_rsp_ready  in  1  consumer takes head
- rd_rsp_data  out  FETCH_WIDTH×DATA_WIDTH  response buffer head
- mem_addr_in_bank  out  ADDR_WIDTH  to SRAM wrapper
- mem_cen_in_bank  out  1  active-high access enable (wrapper inverts)
- mem_wen_in_bank  out  1  active-high write (wrapper inverts)
- mem_data_in_bank  out  FETCH_WIDTH×DATA_WIDTH  write row to wrapper
- mem_data_out_bank  in  FETCH_WIDTH×DATA_WIDTH  SRAM Q, valid the cycle after a read

## Operation
- Eligibility: write is eligible when wr_valid && clk_en. Read is eligible when rd_valid && clk_en && (outstanding − pop) < 2, where outstanding = read_inflight + buffer count, and pop = rd_rsp_valid && rd_rsp_ready.
- Grant: at most one grant per cycle. If only one requester is eligible, it is granted. If both are eligible, the requester not recorded in last_grant wins. last_grant updates on every grant and resets to READ, so a write wins the first contention.
- wr_ready and rd_ready are combinational and equal the respective grant. Ready depends on valid by design.
- Granted write: mem_cen=1, mem_wen=1, mem_addr=wr_addr, mem_data_in=wr_data.
- Granted read: mem_cen=1, mem_wen=0, mem_addr=rd_addr, and read_inflight is set for the next cycle.
- No grant: mem_cen=0, mem_wen=0, mem_addr=0, mem_data_in=0.
- Capture: when read_inflight=1, mem_data_out_bank is pushed into the 2-entry FIFO at the end of that cycle. A push and a pop in the same cycle are both performed. Credit accounting guarantees the FIFO never overflows, and a push into a full FIFO is unreachable (verification asserts this).
- rd_rsp_data is the FIFO head and holds stable while rd_rsp_valid && !rd_rsp_ready.
- clk_en low: no new grants. An in-flight capture and response pops still proceed.
- Width: outstanding is a 2-bit saturating-free count in the range 0..2.

## Timing
- Reset values (asynchronous, immediate on rst_n low): rd_rsp_valid=0, read_inflight=0, FIFO count=0, last_grant=READ. Combinational mem outputs evaluate to 0 when no grant.
- Write latency: the SRAM write occurs on the clock edge ending the grant cycle.
- Read latency: read granted in cycle t, SRAM Q valid in t+1, rd_rsp_valid=1 with data in t+2.
- Throughput: one read per cycle sustained while rd_rsp_ready=1. With rd_rsp_ready=0, at most 2 reads are accepted, then rd_ready=0 until a pop.
- Reset mid-operation: an in-flight read and any buffered responses are discarded. No response is produced after reset releases unless a new read is granted.

## Test plan
- Single write then read: write addr 0x05 with {0x4444,0x3333,0x2222,0x1111}, then read 0x05 → rd_rsp_valid in read cycle+2 with identical row. mem_cen=1 in exactly 2 cycles.
- Contention: wr_valid and rd_valid held high for 6 cycles from reset → grant order W,R,W,R,W,R. Each ready is one-hot per cycle.
- Backpressure: rd_rsp_ready=0 and rd_valid held high on addrs 1,2,3 → only 1,2 accepted and rd_ready stays 0. Raise rd_rsp_ready → data 1 then 2 in order, then addr 3 is granted in the cycle of the first pop.
- Streaming: rd_rsp_ready=1 with 8 back-to-back reads on addrs 0..7 → rd_ready=1 every cycle, 8 responses in consecutive cycles, in order.
- clk_en low for 3 cycles with both requesters valid → no grants, mem_cen=0. An in-flight read issued before clk_en fell still returns.
- Reset mid-stream: assert rst_n=0 one cycle after a read grant → rd_rsp_valid drops immediately. After release, no stale response appears and the first contention grants the write.
